csr_file: RTL
=============

# csr_file

Parametrised machine-mode CSR file for the tartaruga core, sitting in decode beside the register file. It generalises the two-register exception CSR block with a configurable data width, full RW/RS/RC CSR instruction semantics, trap entry and `mret` return handling for `mstatus`, and direct/vectored `mtvec`. It also adds free-running 64-bit `mcycle`/`minstret` counters and detection of illegal CSR accesses.

## Interface
- `XLEN`, 32: data width; 32 or 64 only.
- `MTVEC_RESET`, 32'h0000_0000: reset value of `mtvec` (zero-extended to XLEN).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock, reset synchronous and active-high.
- `csr_valid_i` in 1: a CSR instruction is issued this cycle.
- `csr_op_i` in 2: 01 RW, 10 RS (set), 11 RC (clear); 00 treated as no-op.
- `csr_addr_i` in 12: CSR address.
- `csr_wdata_i` in XLEN: rs1 value or zero-extended uimm.
- `csr_rdata_o` out XLEN: old CSR value, combinational.
- `csr_illegal_o` out 1: access is illegal; no state change.
- `xcpt_i` in 1: take trap this cycle.
- `xcpt_intr_i` in 1: trap is an interrupt.
- `xcpt_code_i` in 5: cause code.
- `xcpt_pc_i` in XLEN: faulting PC.
- `xcpt_value_i` in XLEN: value for `mtval`.
- `mret_i` in 1: `mret` retires this cycle.
- `instr_retired_i` in 1: one instruction retired this cycle.
- `trap_vector_o` out XLEN: trap target PC, combinational.
- `mret_pc_o` out XLEN: current `mepc`.
- `irq_enable_o` out 1: `mstatus.MIE`.

## Operation
- Implemented CSRs: `mstatus` 0x300 (MIE bit 3, MPIE bit 7, MPP bits 12:11 hardwired 2'b11, other bits read 0). `mtvec` 0x305. `mscratch` 0x340. `mepc` 0x341. `mcause` 0x342. `mtval` 0x343. `mcycle` 0xB00. `minstret` 0xB02. For XLEN=32 only: `mcycleh` 0xB80 and `minstreth` 0xB82.
- New value: RW is wdata; RS is old|wdata; RC is old&~wdata.
- A write occurs when `csr_valid_i` and op≠00, except RS/RC with `csr_wdata_i`==0, which is read-only (no write, no side effects).
- `csr_illegal_o`=1 when `csr_valid_i` and the address is unimplemented. It is also 1 for a write to `csr_addr_i[11:10]`==2'b11 (read-only space). On illegal access `csr_rdata_o`=0 and no state changes.
- WARL fields:
  - `mepc[1:0]` always 0.
  - `mtvec[1]` always 0, so mode ∈ {0 direct, 1 vectored}.
  - `mcause` stores the full written value.
- Trap (`xcpt_i`):
  - `mepc`←pc with bits[1:0] cleared.
  - `mcause`←{intr, 0…, code}, with intr at bit XLEN-1.
  - `mtval`←value.
  - MPIE←MIE, MIE←0.
- `mret_i`: MIE←MPIE, MPIE←1.
- `trap_vector_o`: {mtvec[XLEN-1:2],2'b00}; when mode=1 and `xcpt_intr_i`=1, add 4·code.
- Counters are 64 bits:
  - `mcycle` increments every cycle out of reset.
  - `minstret` increments when `instr_retired_i`.
  - Wrap 2^64-1→0 silently.
  - For XLEN=64 the full counter is read and written at the low address.

## Timing
- Reset (`rst_i` high at an edge): all CSRs 0 except `mtvec`=MTVEC_RESET and MPP=2'b11. Outputs after reset: `csr_rdata_o`=0, `csr_illegal_o`=0, `mret_pc_o`=0, `irq_enable_o`=0, `trap_vector_o`=MTVEC_RESET&~3. Reset overrides every concurrent event.
- Reads are zero-latency from current state; writes are visible the cycle after the edge.
- Priority within a cycle is `xcpt_i` > `mret_i` > CSR write. The losing events are dropped, including the whole CSR write. Counters still tick.
- A CSR write to a counter half in the same cycle as its increment: the written half takes the written value with no increment. The other half keeps its old value, so no carry propagates that cycle.
- The `minstret` increment applies even on a cycle with `xcpt_i`.

## Test plan
- Reset: after `rst_i`, read 0x300 → 0x1800, 0x305 → MTVEC_RESET, 0xB00 → a small value equal to the number of cycles elapsed since reset.
- CSR ops on `mscratch`: RW 0xF0F0 → next read 0xF0F0. RS 0x000F → 0xF0FF. RC 0x00F0 → 0xF00F. RS with wdata 0 on 0xB00 → no illegal and no write.
- Illegal: RW to 0x7C0 or to 0xF11 → `csr_illegal_o`=1, `csr_rdata_o`=0, no state change. RS with wdata 0 on 0xF11 → still illegal, since 0xF11 is unimplemented.
- Trap/return: MIE=1, `mtvec`=0x1001, `xcpt_i` with intr=1, code 7, pc 0x2006 in the same cycle as a CSR write:
  - Same cycle: `trap_vector_o`=0x101C.
  - Next cycle: `mepc`=0x2004, `mcause`=0x8000_0007, MIE=0, MPIE=1, CSR write dropped.
  - Then `mret_i` → MIE=1.
- Counter carry (XLEN=32): write `mcycle`=0xFFFF_FFFE. Two cycles later `mcycleh` has incremented by 1 and `mcycle` reads 0x0000_0000. Write `mcycleh` on the wrap cycle → written value wins.
- `instr_retired_i` held for 10 cycles while `mcycle` is written → `minstret` +10, `mcycle` restarts from the written value.

Source files
------------

// File: rtl/csr_file.sv
// Machine-mode CSR file for the tartaruga core.
//
// Holds mstatus (MIE/MPIE, MPP fixed to M), mtvec, mscratch, mepc, mcause,
// mtval and the 64-bit mcycle/minstret counters. Executes RW/RS/RC CSR
// instructions, trap entry and mret, and flags illegal CSR accesses.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   csr_valid_i           CSR instruction issued this cycle
//   csr_op_i              01 RW, 10 RS, 11 RC, 00 no-op
//   csr_addr_i            CSR address
//   csr_wdata_i           rs1 value or zero-extended uimm
//   csr_rdata_o           old CSR value (combinational, 0 when idle/illegal)
//   csr_illegal_o         access is illegal, no state change
//   xcpt_i, xcpt_intr_i   take trap / trap is an interrupt
//   xcpt_code_i           cause code
//   xcpt_pc_i             faulting PC
//   xcpt_value_i          value for mtval
//   mret_i                mret retires this cycle
//   instr_retired_i       one instruction retired this cycle
//   trap_vector_o         trap target PC (combinational)
//   mret_pc_o             current mepc
//   irq_enable_o          mstatus.MIE
module csr_file #(
    parameter int unsigned XLEN        = 32,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            csr_valid_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            xcpt_i,
    input  logic            xcpt_intr_i,
    input  logic [4:0]      xcpt_code_i,
    input  logic [XLEN-1:0] xcpt_pc_i,
    input  logic [XLEN-1:0] xcpt_value_i,
    input  logic            mret_i,
    input  logic            instr_retired_i,
    output logic [XLEN-1:0] trap_vector_o,
    output logic [XLEN-1:0] mret_pc_o,
    output logic            irq_enable_o
);

    localparam bit Is32 = (XLEN == 32);

    localparam logic [11:0] CsrMstatus   = 12'h300;
    localparam logic [11:0] CsrMtvec     = 12'h305;
    localparam logic [11:0] CsrMscratch  = 12'h340;
    localparam logic [11:0] CsrMepc      = 12'h341;
    localparam logic [11:0] CsrMcause    = 12'h342;
    localparam logic [11:0] CsrMtval     = 12'h343;
    localparam logic [11:0] CsrMcycle    = 12'hB00;
    localparam logic [11:0] CsrMinstret  = 12'hB02;
    localparam logic [11:0] CsrMcycleh   = 12'hB80;
    localparam logic [11:0] CsrMinstreth = 12'hB82;

    localparam logic [1:0] OpNone = 2'b00;
    localparam logic [1:0] OpRw   = 2'b01;
    localparam logic [1:0] OpRs   = 2'b10;
    localparam logic [1:0] OpRc   = 2'b11;

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] csr_old;
    logic [XLEN-1:0] csr_new;
    logic            csr_impl;
    logic            wr_req;
    logic            csr_illegal;
    logic            csr_we;
    logic [XLEN-1:0] trap_base;

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mpie_q;
        mstatus_rd[3]     = mie_q;
    end

    // Address decode and read mux
    always_comb begin
        csr_impl = 1'b1;
        csr_old  = '0;
        case (csr_addr_i)
            CsrMstatus:  csr_old = mstatus_rd;
            CsrMtvec:    csr_old = mtvec_q;
            CsrMscratch: csr_old = mscratch_q;
            CsrMepc:     csr_old = mepc_q;
            CsrMcause:   csr_old = mcause_q;
            CsrMtval:    csr_old = mtval_q;
            CsrMcycle:   csr_old = mcycle_q[XLEN-1:0];
            CsrMinstret: csr_old = minstret_q[XLEN-1:0];
            CsrMcycleh: begin
                if (Is32) csr_old = XLEN'(mcycle_q[63:32]);
                else      csr_impl = 1'b0;
            end
            CsrMinstreth: begin
                if (Is32) csr_old = XLEN'(minstret_q[63:32]);
                else      csr_impl = 1'b0;
            end
            default: csr_impl = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read: no write, no side effects
    assign wr_req = csr_valid_i && (csr_op_i != OpNone) &&
                    !((csr_op_i != OpRw) && (csr_wdata_i == '0));

    assign csr_illegal = csr_valid_i &&
                         (!csr_impl || (wr_req && (csr_addr_i[11:10] == 2'b11)));

    // Traps and mret drop the whole concurrent CSR write
    assign csr_we = wr_req && !csr_illegal && !xcpt_i && !mret_i;

    always_comb begin
        case (csr_op_i)
            OpRw:    csr_new = csr_wdata_i;
            OpRs:    csr_new = csr_old | csr_wdata_i;
            OpRc:    csr_new = csr_old & ~csr_wdata_i;
            default: csr_new = csr_old;
        endcase
    end

    // Next-state logic: xcpt > mret > CSR write; counters always advance
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + 64'(instr_retired_i);

        if (xcpt_i) begin
            mepc_d             = xcpt_pc_i;
            mepc_d[1:0]        = 2'b00;
            mcause_d           = '0;
            mcause_d[XLEN-1]   = xcpt_intr_i;
            mcause_d[4:0]      = xcpt_code_i;
            mtval_d            = xcpt_value_i;
            mpie_d             = mie_q;
            mie_d              = 1'b0;
        end else if (mret_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr_i)
                CsrMstatus: begin
                    mie_d  = csr_new[3];
                    mpie_d = csr_new[7];
                end
                CsrMtvec: begin
                    mtvec_d    = csr_new;
                    mtvec_d[1] = 1'b0;
                end
                CsrMscratch: mscratch_d = csr_new;
                CsrMepc: begin
                    mepc_d      = csr_new;
                    mepc_d[1:0] = 2'b00;
                end
                CsrMcause: mcause_d = csr_new;
                CsrMtval:  mtval_d  = csr_new;
                // A written half replaces the increment; the other half holds
                CsrMcycle: begin
                    mcycle_d = 64'(csr_new);
                    if (Is32) mcycle_d[63:32] = mcycle_q[63:32];
                end
                CsrMinstret: begin
                    minstret_d = 64'(csr_new);
                    if (Is32) minstret_d[63:32] = minstret_q[63:32];
                end
                CsrMcycleh:   mcycle_d   = {csr_new[31:0], mcycle_q[31:0]};
                CsrMinstreth: minstret_d = {csr_new[31:0], minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= XLEN'(MTVEC_RESET);
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};

    always_comb begin
        trap_vector_o = trap_base;
        if (mtvec_q[0] && xcpt_intr_i) begin
            trap_vector_o = trap_base + XLEN'({xcpt_code_i, 2'b00});
        end
    end

    assign csr_rdata_o   = (csr_valid_i && !csr_illegal) ? csr_old : '0;
    assign csr_illegal_o = csr_illegal;
    assign mret_pc_o     = mepc_q;
    assign irq_enable_o  = mie_q;

endmodule
